// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per RUN cycle, results held
// in output registers until the next completion or reset.
module div_seq #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    output logic [SIZE-1:0] Q,
    output logic [SIZE-1:0] R,
    output logic            busy,
    output logic            done,
    output logic            dbz,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is a one-cycle request taken only while busy=0; done is a
    // one-cycle pulse during which Q/R/dbz are valid (and they stay valid after).

    state_t          state_q, state_d;
    logic [SIZE-1:0] rem_q, rem_d;
    logic [SIZE-1:0] quo_q, quo_d;
    logic [SIZE-1:0] b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] q_q, q_d;
    logic [SIZE-1:0] r_q, r_d;
    logic            dbz_q, dbz_d;

    logic            accept;
    logic [SIZE:0]   rem_sh;
    logic [SIZE:0]   trial;
    logic [SIZE-1:0] rem_nx;
    logic [SIZE-1:0] quo_nx;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        accept  = start && (state_q != RUN);

        // The shifted remainder needs SIZE+1 bits; the top bit of trial is the borrow.
        rem_sh  = {rem_q, quo_q[SIZE-1]};
        trial   = rem_sh - {1'b0, b_q};
        if (trial[SIZE]) begin
            rem_nx = rem_sh[SIZE-1:0];
            quo_nx = {quo_q[SIZE-2:0], 1'b0};
        end else begin
            rem_nx = trial[SIZE-1:0];
            quo_nx = {quo_q[SIZE-2:0], 1'b1};
        end

        case (state_q)
            RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SIZE - 1)) begin
                    state_d = DONE;
                    q_d     = quo_nx;
                    r_d     = rem_nx;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            b_d   = B;
            cnt_d = '0;
            if (B == '0) begin
                state_d = DONE;
                rem_d   = '0;
                quo_d   = '0;
                q_d     = '1;
                r_d     = A;
                dbz_d   = 1'b1;
            end else begin
                state_d = RUN;
                rem_d   = '0;
                quo_d   = A;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Q         = q_q;
    assign R         = r_q;
    assign dbz       = dbz_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

endmodule
